reset_extender: RTL and testbench

RESET_EXTENDER -- requirements
Module: reset_extender

---
 rtl/reset_extender_pkg.sv | 21 ++
 rtl/reset_extender_bit_sync.sv | 23 ++
 rtl/reset_extender.sv | 117 +++++++++++
 tb/tb_reset_extender.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/reset_extender_pkg.sv
// Shared state type and encodings for the reset extender.
package reset_extender_pkg;

  localparam logic [1:0] ENC_RST     = 2'b00;
  localparam logic [1:0] ENC_WAIT_PG = 2'b01;
  localparam logic [1:0] ENC_STRETCH = 2'b10;
  localparam logic [1:0] ENC_RUN     = 2'b11;

  typedef enum logic [1:0] {
    ST_RST     = ENC_RST,
    ST_WAIT_PG = ENC_WAIT_PG,
    ST_STRETCH = ENC_STRETCH,
    ST_RUN     = ENC_RUN
  } rst_ext_state_t;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;
  localparam int unsigned HOLD_CYCLES_MIN = 2;
  localparam int unsigned HOLD_CYCLES_MAX = 65535;

endpackage

// File: rtl/reset_extender_bit_sync.sv
// Parameterized flop-chain synchronizer with asynchronous active-high clear.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_extender.sv
// Extends reset until synchronized power-good is stable plus a hold period.
// Optional power-good debounce filter: define RESET_EXTENDER_DEBOUNCE_EN.
module reset_extender
  import reset_extender_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic pwrgood_in,
  input  logic sw_reset_req,
  output logic areset_out,
  output logic reset_done
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX ||
      HOLD_CYCLES < HOLD_CYCLES_MIN || HOLD_CYCLES > HOLD_CYCLES_MAX ||
      DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("reset_extender: parameter out of legal range");
  end

  logic           pg_s;
  rst_ext_state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic           areset_q;
  logic           done_q;

`ifdef RESET_EXTENDER_DEBOUNCE_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES);
  logic [DB_W-1:0] db_q;
`endif

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_pg_sync (
    .clk_i(clock),
    .clr_i(reset),
    .d_i  (pwrgood_in),
    .q_o  (pg_s)
  );

  // Outputs are registered decodes of state_q, so they follow the state by
  // one edge; this extra edge is part of the release latency budget.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RST;
      cnt_q    <= '0;
      areset_q <= 1'b1;
      done_q   <= 1'b0;
`ifdef RESET_EXTENDER_DEBOUNCE_EN
      db_q     <= '0;
`endif
    end else begin
      areset_q <= (state_q != ST_RUN);
      done_q   <= (state_q == ST_RUN);
      case (state_q)
        ST_RST: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT_PG;
        end
        ST_WAIT_PG: begin
          cnt_q <= '0;
`ifdef RESET_EXTENDER_DEBOUNCE_EN
          // Transition needs DEBOUNCE_CYCLES high samples before the entry one.
          if (!pg_s) begin
            db_q <= '0;
          end else if (db_q == DB_LAST) begin
            db_q    <= '0;
            state_q <= ST_STRETCH;
          end else begin
            db_q <= db_q + DB_W'(1);
          end
`else
          if (pg_s) begin
            state_q <= ST_STRETCH;
          end
`endif
        end
        ST_STRETCH: begin
          if (!pg_s) begin
            cnt_q   <= '0;
            state_q <= ST_WAIT_PG;
          end else if (sw_reset_req) begin
            cnt_q <= '0;
          end else if (cnt_q == HOLD_LAST) begin
            state_q <= ST_RUN;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!pg_s) begin
            cnt_q   <= '0;
            state_q <= ST_WAIT_PG;
          end else if (sw_reset_req) begin
            cnt_q   <= '0;
            state_q <= ST_STRETCH;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_RST;
        end
      endcase
    end
  end

  assign areset_out = areset_q;
  assign reset_done = done_q;

endmodule

// File: tb/tb_reset_extender.sv
// Self-checking bench for reset_extender: vector table plus multi-cycle corner sequences.
module tb_reset_extender;
  import reset_extender_pkg::*;

  localparam int unsigned SS = 2;
  localparam int unsigned HC = 16;
  localparam int unsigned DC = 8;
`ifdef RESET_EXTENDER_DEBOUNCE_EN
  localparam int unsigned DB = DC;
`else
  localparam int unsigned DB = 0;
`endif
  localparam int unsigned NV = 21;

  logic clock = 1'b0;
  logic reset;
  logic pwrgood_in;
  logic sw_reset_req;
  logic areset_out;
  logic reset_done;

  reset_extender #(
    .SYNC_STAGES    (SS),
    .HOLD_CYCLES    (HC),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pwrgood_in  (pwrgood_in),
    .sw_reset_req(sw_reset_req),
    .areset_out  (areset_out),
    .reset_done  (reset_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        pg;
    logic        sw;
    int unsigned ncyc;
    logic        exp_ar;
    logic        exp_done;
  } vec_t;

  typedef struct {
    string name;
    logic  ar;
    logic  done;
  } exp_t;

  vec_t vecs[NV];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: got empty queue want entry");
    end else begin
      e = sb.pop_front();
      chk({e.name, "_areset"}, 32'(areset_out), 32'(e.ar));
      chk({e.name, "_done"}, 32'(reset_done), 32'(e.done));
    end
  endtask

  // sw is a single-edge pulse on the first edge of the record; pg is held.
  task automatic apply_vec(input vec_t v);
    pwrgood_in   = v.pg;
    sw_reset_req = v.sw;
    sb.push_back('{v.name, v.exp_ar, v.exp_done});
    for (int unsigned i = 0; i < v.ncyc; i++) begin
      @(posedge clock);
      #1;
      sw_reset_req = 1'b0;
    end
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs = '{
      '{"wait_pg_low",   1'b0, 1'b0, 4,       1'b1, 1'b0},
      '{"pwrup_hold",    1'b1, 1'b0, 18 + DB, 1'b1, 1'b0},
      '{"pwrup_last",    1'b1, 1'b0, 1,       1'b1, 1'b0},
      '{"pwrup_release", 1'b1, 1'b0, 1,       1'b0, 1'b1},
      '{"run_steady",    1'b1, 1'b0, 5,       1'b0, 1'b1},
      '{"drop_edge",     1'b0, 1'b0, 1,       1'b0, 1'b1},
      '{"drop_sync",     1'b1, 1'b0, 1,       1'b0, 1'b1},
      '{"drop_state",    1'b1, 1'b0, 1,       1'b0, 1'b1},
      '{"drop_areset",   1'b1, 1'b0, 1,       1'b1, 1'b0},
      '{"rec_hold",      1'b1, 1'b0, 15 + DB, 1'b1, 1'b0},
      '{"rec_last",      1'b1, 1'b0, 1,       1'b1, 1'b0},
      '{"rec_release",   1'b1, 1'b0, 1,       1'b0, 1'b1},
      '{"sw_edge",       1'b1, 1'b1, 1,       1'b0, 1'b1},
      '{"sw_areset",     1'b1, 1'b0, 1,       1'b1, 1'b0},
      '{"sw_hold",       1'b1, 1'b0, 15,      1'b1, 1'b0},
      '{"sw_release",    1'b1, 1'b0, 1,       1'b0, 1'b1},
      '{"sw2_first",     1'b1, 1'b1, 1,       1'b0, 1'b1},
      '{"sw2_count10",   1'b1, 1'b0, 10,      1'b1, 1'b0},
      '{"sw2_second",    1'b1, 1'b1, 1,       1'b1, 1'b0},
      '{"sw2_hold",      1'b1, 1'b0, 16,      1'b1, 1'b0},
      '{"sw2_release",   1'b1, 1'b0, 1,       1'b0, 1'b1}
    };

    reset        = 1'b1;
    pwrgood_in   = 1'b0;
    sw_reset_req = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_areset", 32'(areset_out), 32'd1);
    chk("rst_done", 32'(reset_done), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_RST));
    reset = 1'b0;

    for (int unsigned i = 0; i < NV; i++) begin
      apply_vec(vecs[i]);
    end

    // Conflict: sw pulse lands on the edge that sees pg_s fall.
    pwrgood_in = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    sw_reset_req = 1'b1;
    @(posedge clock); #1;
    sw_reset_req = 1'b0;
    chk("conflict_state", 32'(dut.state_q), 32'(ST_WAIT_PG));
    @(posedge clock); #1;
    chk("conflict_areset", 32'(areset_out), 32'd1);
    chk("conflict_done", 32'(reset_done), 32'd0);

    sw_reset_req = 1'b1;
    @(posedge clock); #1;
    sw_reset_req = 1'b0;
    chk("waitpg_sw_ignored", 32'(dut.state_q), 32'(ST_WAIT_PG));
    repeat (3) @(posedge clock);
    #1;
    chk("waitpg_areset", 32'(areset_out), 32'd1);

    // Abort with reset at STRETCH count 7.
    pwrgood_in = 1'b1;
    repeat (10 + DB) @(posedge clock);
    #1;
    chk("stretch_cnt7", 32'(dut.cnt_q), 32'd7);
    chk("stretch_state", 32'(dut.state_q), 32'(ST_STRETCH));
    reset = 1'b1;
    #1;
    chk("abort_str_areset", 32'(areset_out), 32'd1);
    chk("abort_str_cnt", 32'(dut.cnt_q), 32'd0);
    chk("abort_str_state", 32'(dut.state_q), 32'(ST_RST));
    #2;
    reset = 1'b0;
    repeat (19 + DB) @(posedge clock);
    #1;
    chk("restart_hold", 32'(areset_out), 32'd1);
    @(posedge clock); #1;
    chk("restart_release", 32'(areset_out), 32'd0);
    chk("restart_done", 32'(reset_done), 32'd1);

    // Abort from RUN: output must rise without waiting for a clock edge.
    reset = 1'b1;
    #1;
    chk("abort_run_areset", 32'(areset_out), 32'd1);
    chk("abort_run_done", 32'(reset_done), 32'd0);
    chk("abort_run_state", 32'(dut.state_q), 32'(ST_RST));

`ifdef RESET_EXTENDER_DEBOUNCE_EN
    pwrgood_in = 1'b0;
    #2;
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    for (int r = 0; r < 2; r++) begin
      pwrgood_in = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      pwrgood_in = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("glitch_state", 32'(dut.state_q), 32'(ST_WAIT_PG));
      chk("glitch_areset", 32'(areset_out), 32'd1);
    end
    pwrgood_in = 1'b1;
    repeat (27) @(posedge clock);
    #1;
    chk("db_hold", 32'(areset_out), 32'd1);
    @(posedge clock); #1;
    chk("db_release", 32'(areset_out), 32'd0);
    chk("db_done", 32'(reset_done), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
